// File: rtl/data_memory_pkg.sv
// Shared types and geometry for the line-oriented main-memory model.
// Geometry, index slice bounds, FSM state type and the captured-request payload.
package data_memory_pkg;

  localparam int unsigned LINE_W      = 256;
  localparam int unsigned DEPTH       = 512;
  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned IDX_HI      = 13;
  localparam int unsigned IDX_LO      = 5;
  localparam int unsigned IDX_W       = IDX_HI - IDX_LO + 1;
  localparam int unsigned MEM_LATENCY = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  // Request fields frozen at the accepting edge.
  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [LINE_W-1:0] data;
    logic              write;
  } req_t;

endpackage

// File: rtl/data_memory_if.sv
// Cache-to-memory request/response bus: enable/ack handshake, one line per access.
interface data_memory_if;
  import data_memory_pkg::*;

  logic [ADDR_W-1:0] addr_i;
  logic [LINE_W-1:0] data_i;
  logic              enable_i;
  logic              write_i;
  logic              ack_o;
  logic [LINE_W-1:0] data_o;

  modport master (
    output addr_i, data_i, enable_i, write_i,
    input  ack_o, data_o
  );

  modport slave (
    input  addr_i, data_i, enable_i, write_i,
    output ack_o, data_o
  );

endinterface

// File: rtl/data_memory.sv
// Fixed-latency main-memory model: 512 x 256-bit lines, one whole line per
// enable/ack transaction. Storage is not reset; a reset aborts any access in flight.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int unsigned LATENCY = MEM_LATENCY
) (
  input  logic          clk_i,
  input  logic          rst_i,
  data_memory_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(LATENCY);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

  logic [LINE_W-1:0] memory [0:DEPTH-1];

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  req_t              req_q, req_d;
  logic              ack_q, ack_d;
  logic [LINE_W-1:0] data_q, data_d;
  logic              mem_we;

  logic [IDX_W-1:0]  line_idx;
  logic              unused_addr;

  // Offset and upper address bits are discarded, so addresses alias modulo 16 KB.
  assign line_idx    = bus.addr_i[IDX_HI:IDX_LO];
  assign unused_addr = ^{bus.addr_i[ADDR_W-1:IDX_HI+1], bus.addr_i[IDX_LO-1:0]};

  // Next-state, counter and output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    ack_d   = 1'b0;
    data_d  = data_q;
    mem_we  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.enable_i) begin
          req_d.idx   = line_idx;
          req_d.data  = bus.data_i;
          req_d.write = bus.write_i;
          cnt_d       = '0;
          state_d     = WAIT;
        end
      end

      WAIT: begin
        if (cnt_q == CNT_LAST) begin
          ack_d   = 1'b1;
          cnt_d   = '0;
          state_d = ACK;
          if (req_q.write) begin
            mem_we = 1'b1;
            data_d = req_q.data;
          end else begin
            data_d = memory[req_q.idx];
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // Enable is deliberately ignored here so a held request cannot re-issue.
      ACK: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counter, request and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      ack_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      ack_q   <= ack_d;
      data_q  <= data_d;
    end
  end

  // Array write; reset on the completion edge suppresses the pending write.
  always_ff @(posedge clk_i) begin
    if (!rst_i && mem_we) begin
      memory[req_q.idx] <= req_q.data;
    end
  end

  assign bus.ack_o  = ack_q;
  assign bus.data_o = data_q;

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: randomized line traffic against an
// array-based reference model of the memory contents and handshake timing.
module tb_data_memory;
  import data_memory_pkg::*;

  localparam int EXP_LAT = 10;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  logic [255:0] ref_mem [0:511];

  data_memory_if bus ();

  data_memory dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // Line number from a byte address: 32-byte lines, 512 of them, wrapping.
  function automatic int idx_of(input logic [31:0] a);
    return int'((a / 32) % 512);
  endfunction

  // Issue one request, scramble the bus while it is in flight, return ack timing.
  task automatic run_txn(input logic [31:0] a, input logic [255:0] d, input logic w,
                         output int lat, output logic [255:0] rd, output logic ack_after);
    @(negedge clk);
    bus.addr_i   = a;
    bus.data_i   = d;
    bus.write_i  = w;
    bus.enable_i = 1'b1;
    @(posedge clk);
    #1;
    bus.addr_i  = $urandom();
    bus.data_i  = rand256();
    bus.write_i = ~w;
    lat = -1;
    rd  = '0;
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) #1;
      @(posedge clk);
      #1;
      if (bus.ack_o === 1'b1) begin
        lat = k + 0;
        break;
      end
    end
    rd = bus.data_o;
    bus.enable_i = 1'b0;
    @(posedge clk);
    #1;
    ack_after = bus.ack_o;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.enable_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (bus.ack_o !== 1'b0) begin
      bad++; $display("FAIL reset_ack: got %b want 0", bus.ack_o);
    end
    total++;
    if (bus.data_o !== 256'h0) begin
      bad++; $display("FAIL reset_data: got %h want 0", bus.data_o);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_read_basic();
    int lat; logic [255:0] rd; logic aa;
    @(negedge clk);
    dut.memory[0] <= 256'h5;
    ref_mem[0] = 256'h5;
    #1;
    run_txn(32'h0, rand256(), 1'b0, lat, rd, aa);
    total++;
    if (lat != EXP_LAT) begin bad++; $display("FAIL read_latency: got %0d want %0d", lat, EXP_LAT); end
    total++;
    if (rd !== 256'h5) begin bad++; $display("FAIL read_data: got %h want 5", rd); end
    total++;
    if (aa !== 1'b0) begin bad++; $display("FAIL read_ack_width: got %b want 0", aa); end
  endtask

  task automatic test_write_read();
    int lat; logic [255:0] rd; logic aa; logic [255:0] pat; logic [255:0] seen;
    pat = {32{8'hA5}};
    run_txn(32'h400, pat, 1'b1, lat, rd, aa);
    ref_mem[idx_of(32'h400)] = pat;
    total++;
    if (lat != EXP_LAT) begin bad++; $display("FAIL write_latency: got %0d want %0d", lat, EXP_LAT); end
    total++;
    if (rd !== pat) begin bad++; $display("FAIL write_echo: got %h want %h", rd, pat); end
    seen = dut.memory[32];
    total++;
    if (seen !== pat) begin bad++; $display("FAIL write_array: got %h want %h", seen, pat); end
    total++;
    if (aa !== 1'b0) begin bad++; $display("FAIL write_ack_width: got %b want 0", aa); end
    run_txn(32'h400, rand256(), 1'b0, lat, rd, aa);
    total++;
    if (rd !== pat) begin bad++; $display("FAIL write_readback: got %h want %h", rd, pat); end
  endtask

  task automatic test_alias();
    int lat; logic [255:0] rd; logic aa;
    logic [31:0] addrs [2];
    addrs[0] = 32'h4000;
    addrs[1] = 32'h1F;
    for (int i = 0; i < 2; i++) begin
      run_txn(addrs[i], rand256(), 1'b0, lat, rd, aa);
      total++;
      if (rd !== ref_mem[0]) begin
        bad++; $display("FAIL alias_%h: got %h want %h", addrs[i], rd, ref_mem[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0]  a [3];
    logic [255:0] d0;
    int edges [$];
    int n;
    a[0] = $urandom();
    a[1] = a[0] ^ 32'hFFFF_C000;
    a[2] = $urandom();
    d0   = rand256();
    n    = 0;
    @(negedge clk);
    bus.addr_i   = a[0];
    bus.data_i   = d0;
    bus.write_i  = 1'b1;
    bus.enable_i = 1'b1;
    @(posedge clk);
    for (int e = 1; e <= 45; e++) begin
      @(posedge clk);
      #1;
      if (bus.ack_o === 1'b1) begin
        edges.push_back(e);
        if (n == 0) begin
          ref_mem[idx_of(a[0])] = d0;
          total++;
          if (bus.data_o !== d0) begin bad++; $display("FAIL b2b_write: got %h want %h", bus.data_o, d0); end
        end else if (n < 3) begin
          total++;
          if (bus.data_o !== ref_mem[idx_of(a[n])]) begin
            bad++; $display("FAIL b2b_read%0d: got %h want %h", n, bus.data_o, ref_mem[idx_of(a[n])]);
          end
        end
        n++;
        if (n < 3) begin
          bus.addr_i  = a[n];
          bus.data_i  = rand256();
          bus.write_i = 1'b0;
        end else begin
          bus.enable_i = 1'b0;
        end
      end
    end
    bus.enable_i = 1'b0;
    total++;
    if (edges.size() != 3) begin bad++; $display("FAIL b2b_ack_count: got %0d want 3", edges.size()); end
    for (int i = 0; i < edges.size() && i < 3; i++) begin
      total++;
      if (edges[i] != EXP_LAT + i * (EXP_LAT + 2)) begin
        bad++; $display("FAIL b2b_ack_edge%0d: got %0d want %0d", i, edges[i], EXP_LAT + i * (EXP_LAT + 2));
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    int lat; int acks; logic [255:0] rd; logic aa; logic [255:0] seen; logic [255:0] pat;
    logic [31:0] a;
    a   = 32'h0000_1240;
    pat = ~ref_mem[idx_of(a)];
    acks = 0;
    @(negedge clk);
    bus.addr_i   = a;
    bus.data_i   = pat;
    bus.write_i  = 1'b1;
    bus.enable_i = 1'b1;
    @(posedge clk);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    bus.enable_i = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (bus.ack_o !== 1'b0) begin bad++; $display("FAIL abort_ack: got %b want 0", bus.ack_o); end
    total++;
    if (bus.data_o !== 256'h0) begin bad++; $display("FAIL abort_data: got %h want 0", bus.data_o); end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk);
      #1;
      if (bus.ack_o === 1'b1) acks++;
    end
    total++;
    if (acks != 0) begin bad++; $display("FAIL abort_stray_ack: got %0d want 0", acks); end
    seen = dut.memory[idx_of(a)];
    total++;
    if (seen !== ref_mem[idx_of(a)]) begin
      bad++; $display("FAIL abort_no_write: got %h want %h", seen, ref_mem[idx_of(a)]);
    end
    run_txn(a, rand256(), 1'b0, lat, rd, aa);
    total++;
    if (lat != EXP_LAT) begin bad++; $display("FAIL restart_latency: got %0d want %0d", lat, EXP_LAT); end
    total++;
    if (rd !== ref_mem[idx_of(a)]) begin
      bad++; $display("FAIL restart_data: got %h want %h", rd, ref_mem[idx_of(a)]);
    end
  endtask

  task automatic test_random();
    int lat; logic [255:0] rd; logic aa; logic [255:0] d; logic [255:0] exp_d;
    logic [31:0] a; logic w;
    for (int t = 0; t < 12; t++) begin
      a = ($urandom() & 32'hFFFF_C01F) | (32'($urandom_range(0, 7)) << 5);
      w = 1'($urandom_range(0, 1));
      d = rand256();
      run_txn(a, d, w, lat, rd, aa);
      if (w) begin
        ref_mem[idx_of(a)] = d;
        exp_d = d;
      end else begin
        exp_d = ref_mem[idx_of(a)];
      end
      total++;
      if (lat != EXP_LAT || aa !== 1'b0) begin
        bad++; $display("FAIL rand%0d_timing: got lat=%0d ack_after=%b want lat=%0d ack_after=0", t, lat, aa, EXP_LAT);
      end
      total++;
      if (rd !== exp_d) begin bad++; $display("FAIL rand%0d_data: got %h want %h", t, rd, exp_d); end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.addr_i   = '0;
    bus.data_i   = '0;
    bus.write_i  = 1'b0;
    bus.enable_i = 1'b0;
    for (int i = 0; i < 512; i++) begin
      ref_mem[i] = rand256();
      dut.memory[i] <= ref_mem[i];
    end
    #1;
    test_reset();
    test_read_basic();
    test_write_read();
    test_alias();
    test_back_to_back();
    test_reset_mid_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_memory.md
# data_memory

Off-chip main-memory model behind the L1 data cache: a 16 KB array of 512 lines × 256 bits, accessed one whole line per transaction with a fixed multi-cycle latency. It sits at the CPU/cache memory port (`mem_addr_o`/`mem_data_o`/`mem_enable_o`/`mem_write_o` in, `mem_ack_i`/`mem_data_i` out). It serves cache refills and dirty-line write-backs through an enable/ack handshake.

## Interface
- `LINE_W`, 256, line width in bits
- `DEPTH`, 512, number of lines
- `ADDR_W`, 32, byte address width
- `LATENCY`, 10, rising edges from request acceptance to `ack_o` assertion (≥2)
- `clk_i` in 1: single clock; all logic on its rising edge
- `rst_i` in 1: reset, synchronous, active-high
- `addr_i` in ADDR_W: byte address; line index = `addr_i[13:5]`; bits [4:0] and [31:14] ignored
- `data_i` in LINE_W: write line
- `enable_i` in 1: request valid, held by the requester until `ack_o`
- `write_i` in 1: 1 = write, 0 = read; sampled with `enable_i`
- `ack_o` out 1: one-cycle completion pulse
- `data_o` out LINE_W: line returned by the last completed access
- Storage array is named `memory`, declared `[LINE_W-1:0] memory[0:DEPTH-1]`, so benches can preload and inspect it hierarchically.

## Operation
- FSM states: IDLE, WAIT, ACK.
- IDLE: when `enable_i`=1 at an edge, capture `addr_i[13:5]`, `data_i` and `write_i` into request registers, then go to WAIT. Inputs are not re-sampled during WAIT.
- WAIT: a cycle counter advances. At the completion edge:
  - write: `memory[idx] <= data`, and `data_o <= data`.
  - read: `data_o <= memory[idx]`.
  - `ack_o <= 1`, go to ACK.
- ACK: at the next edge, `ack_o <= 0`, go to IDLE. `enable_i` is ignored while in ACK, so a requester that drops enable on the edge where it samples ack never double-issues.
- If `enable_i` is still high in IDLE after ACK, a new transaction starts (back-to-back requests are legal).
- Address aliasing: upper address bits are discarded. 0x4000 maps to line 0.
- `data_o` holds its value between completions.
- Reset:
  - clears `ack_o`=0, `data_o`=0, state=IDLE, counter=0.
  - does not clear `memory`.
  - a reset during WAIT or ACK aborts the transaction, and a pending write is not performed.

## Timing
- Accepting edge = t0. `ack_o` and `data_o` update at edge t0+LATENCY. `ack_o` is high for exactly one cycle and falls at t0+LATENCY+1.
- The earliest next acceptance is at edge t0+LATENCY+2.
- A write is visible in `memory` from edge t0+LATENCY onward.
- All outputs are registered, with no combinational paths from inputs to outputs.

## Structure
- Shared package holds:
  - `LINE_W`, `DEPTH`, `ADDR_W` and the index slice bounds (13:5)
  - the state enum {IDLE, WAIT, ACK}
- Single flat module with no sub-modules. The array, FSM and counter live inline.

## Test plan
- Preload `memory[0]`=256'h5; read at 0x0 accepted at t0. Expect `ack_o` high only in cycle t0+10, with `data_o`=256'h5.
- Write 0x400 with pattern 256'hA5…A5, then read 0x400. Expect `memory[32]` = pattern after the first ack, and the read returns the pattern.
- Read 0x4000 and 0x1F. Both return `memory[0]` (aliasing, offset bits ignored).
- Hold `enable_i` high across ack. Expect exactly one ack per transaction, spaced LATENCY+2 edges apart, and no duplicate write.
- Assert `rst_i` mid-WAIT on a write. Expect `ack_o`=0, `data_o`=0, target line unchanged, and a clean restart afterwards.
- Change `addr_i`/`data_i` during WAIT. Expect the access to use the values captured at t0.
